dmem_bw: RTL and testbench

Parametrised data memory for the single-cycle MIPS CPU. It replaces the word-only data memory with byte, halfword and word access, plus sign or zero extension on loads, so `lb/lbu/lh/lhu/sb/sh/sw` resolve inside the memory. It also adds misalignment detection with a sticky error record and a reset-time clear sequencer. It sits between the ALU address path and the writeback mux.

---
 rtl/dmem_bw_pkg.sv | 28 ++
 rtl/dmem_bw_ram.sv | 30 +++
 rtl/dmem_bw.sv | 157 +++++++++++++++
 tb/tb_dmem_bw.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bw_pkg.sv
// Shared access-size codes, error-address width and clear-FSM state type for the
// byte/half/word data memory. The CPU control unit uses the same size codes.
package dmem_bw_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam int         ERR_ADDR_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // Reserved size code 2'b11 can never be satisfied, so it always faults.
    function automatic logic align_fault(input logic [1:0] sz, input logic [1:0] lo);
        logic fault;
        fault = 1'b1;
        case (sz)
            SIZE_BYTE: fault = 1'b0;
            SIZE_HALF: fault = lo[0];
            SIZE_WORD: fault = |lo;
            default:   fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dmem_bw_ram.sv
// DEPTH x 32 storage split into four byte lanes, each with its own write enable
// on the rising edge, plus an asynchronous read port.
module dmem_bw_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (be[gi]) begin
                    lane_mem[waddr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/dmem_bw.sv
// Byte/half/word data memory with load extension, misalignment detection, a
// sticky first-fault record and a post-reset zero-fill sequencer.
module dmem_bw
    import dmem_bw_pkg::*;
#(
    parameter int DEPTH          = 1024,
    localparam int AW            = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sext,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  misalign,
    output logic                  err,
    output logic [ERR_ADDR_W-1:0] err_addr,
    input  logic                  err_clr
);

    clr_state_t      state_reg, state_next;
    logic [AW-1:0]   idx_reg, idx_next;
    logic            err_reg;
    logic [31:0]     err_addr_reg;

    logic [AW-1:0]   word_idx;
    logic [1:0]      lo;
    logic            fault;
    logic            access_ok;
    logic            clear_wr;
    logic [3:0]      store_be;
    logic [31:0]     store_data;
    logic [3:0]      ram_be;
    logic [AW-1:0]   ram_waddr;
    logic [31:0]     ram_wdata;
    logic [31:0]     ram_rdata;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;

    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign word_idx  = addr[AW+1:2];
    assign lo        = addr[1:0];
    assign busy      = (state_reg == ST_CLEAR);
    assign fault     = align_fault(size, lo);
    assign misalign  = en & ~busy & fault;
    assign access_ok = en & ~busy & ~fault;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        if (state_reg == ST_CLEAR) begin
            idx_next = idx_reg + 1'b1;
            if (idx_reg == AW'(DEPTH - 1)) begin
                state_next = ST_IDLE;
            end
        end
    end

    // ---------------- store lane steering ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be
            always_comb begin
                store_be[gi] = 1'b0;
                case (size)
                    SIZE_BYTE: store_be[gi] = (lo == 2'(gi));
                    SIZE_HALF: store_be[gi] = (lo[1] == 1'(gi / 2));
                    SIZE_WORD: store_be[gi] = 1'b1;
                    default:   store_be[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Replicate narrow data across lanes; the byte enables pick the right copy.
    always_comb begin
        store_data = wdata;
        case (size)
            SIZE_BYTE: store_data = {4{wdata[7:0]}};
            SIZE_HALF: store_data = {2{wdata[15:0]}};
            default:   store_data = wdata;
        endcase
    end

    // The zero-fill owns the write port while the sequencer is running.
    assign clear_wr  = busy & ~rst;
    assign ram_be    = clear_wr ? 4'hF : ((access_ok & we) ? store_be : 4'h0);
    assign ram_waddr = clear_wr ? idx_reg : word_idx;
    assign ram_wdata = clear_wr ? 32'h0 : store_data;

    dmem_bw_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (word_idx),
        .rdata (ram_rdata)
    );

    // ---------------- load extraction / extension ----------------
    always_comb begin
        byte_sel  = ram_rdata[7:0];
        case (lo)
            2'd0:    byte_sel = ram_rdata[7:0];
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            default: byte_sel = ram_rdata[31:24];
        endcase
        half_sel  = lo[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_data = ram_rdata;
        case (size)
            SIZE_BYTE: load_data = {{24{sext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = {{16{sext & half_sel[15]}}, half_sel};
            default:   load_data = ram_rdata;
        endcase
    end

    assign rdata = (access_ok & ~we) ? load_data : 32'h0;

    // ---------------- sticky error record ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg      <= 1'b0;
            err_addr_reg <= 32'h0;
        end else if (err_clr) begin
            err_reg      <= 1'b0;
            err_addr_reg <= 32'h0;
        end else if (misalign && !err_reg) begin
            err_reg      <= 1'b1;
            err_addr_reg <= addr;
        end
    end

    assign err      = err_reg;
    assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_dmem_bw.sv
// Directed bench for dmem_bw with DEPTH=16: table-driven access vectors plus
// hand-written sequences for the clear phase, read-during-write and reset mid-clear.
module tb_dmem_bw;
    import dmem_bw_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, en, we, sext, err_clr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, err_addr;
    logic        busy, misalign, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_bw #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .size     (size),
        .sext     (sext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .misalign (misalign),
        .err      (err),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    typedef struct {
        logic        en;
        logic        we;
        logic        clr;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_err;
        logic [31:0] exp_ea;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd);
        en = e; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    endtask

    // Counts rising edges until busy drops; optional store attempt from edge 3 onward.
    task automatic count_busy(input string name, input bit try_store, output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 2) begin
                drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h6, 32'h0);
                #1;
                chk({name, "_busy_misalign"}, {31'h0, misalign}, 32'h0);
                chk({name, "_busy_rdata"}, rdata, 32'h0);
            end
            if (cnt == 3 && try_store) drive(1'b1, 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hDEADBEEF);
        end
        drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
        chk({name, "_busy_cycles"}, cnt, DEPTH);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'(i * 4), 32'h0);
            #1;
            chk($sformatf("%s_word%0d", name, i), rdata, 32'h0);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic apply(input int n, input vec_t v);
        @(negedge clk);
        drive(v.en, v.we, v.sz, v.sx, v.a, v.wd);
        err_clr = v.clr;
        #1;
        $display("vec %0d en=%0b we=%0b size=%0d sext=%0b addr=0x%08h wdata=0x%08h -> rdata=0x%08h misalign=%0b err=%0b err_addr=0x%08h",
                 n, v.en, v.we, v.sz, v.sx, v.a, v.wd, rdata, misalign, err, err_addr);
        chk($sformatf("vec%0d_rdata", n), rdata, v.exp_rd);
        chk($sformatf("vec%0d_misalign", n), {31'h0, misalign}, {31'h0, v.exp_mis});
        chk($sformatf("vec%0d_err", n), {31'h0, err}, {31'h0, v.exp_err});
        chk($sformatf("vec%0d_err_addr", n), err_addr, v.exp_ea);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; err_clr = 1'b0;
        drive(1'b0, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);

        //       en  we  clr sz         sx  addr    wdata         rdata         mis err err_addr
        vecs.push_back('{1, 1, 0, SIZE_WORD, 0, 32'h08, 32'h00000000, 32'h00000000, 0, 0, 32'h00});
        vecs.push_back('{1, 1, 0, SIZE_BYTE, 0, 32'h09, 32'h00000080, 32'h00000000, 0, 0, 32'h00});
        vecs.push_back('{1, 1, 0, SIZE_HALF, 0, 32'h0A, 32'h0000BEEF, 32'h00000000, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_WORD, 0, 32'h08, 32'h0,        32'hBEEF8000, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_BYTE, 1, 32'h09, 32'h0,        32'hFFFFFF80, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_BYTE, 0, 32'h09, 32'h0,        32'h00000080, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_HALF, 1, 32'h0A, 32'h0,        32'hFFFFBEEF, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_HALF, 0, 32'h0A, 32'h0,        32'h0000BEEF, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_BYTE, 1, 32'h0B, 32'h0,        32'hFFFFFFBE, 0, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_BYTE, 0, 32'h08, 32'h0,        32'h00000000, 0, 0, 32'h00});
        vecs.push_back('{1, 1, 0, SIZE_WORD, 0, 32'h06, 32'h12345678, 32'h00000000, 1, 0, 32'h00});
        vecs.push_back('{1, 0, 0, SIZE_WORD, 0, 32'h04, 32'h0,        32'h00000000, 0, 1, 32'h06});
        vecs.push_back('{1, 0, 0, SIZE_WORD, 0, 32'h08, 32'h0,        32'hBEEF8000, 0, 1, 32'h06});
        vecs.push_back('{1, 0, 0, SIZE_HALF, 1, 32'h03, 32'h0,        32'h00000000, 1, 1, 32'h06});
        vecs.push_back('{1, 0, 0, SIZE_BYTE, 0, 32'h03, 32'h0,        32'h00000000, 0, 1, 32'h06});
        vecs.push_back('{1, 0, 1, SIZE_WORD, 0, 32'h01, 32'h0,        32'h00000000, 1, 1, 32'h06});
        vecs.push_back('{1, 0, 0, 2'b11,     0, 32'h20, 32'h0,        32'h00000000, 1, 0, 32'h00});
        vecs.push_back('{0, 0, 0, SIZE_WORD, 0, 32'h02, 32'h0,        32'h00000000, 0, 1, 32'h20});
        vecs.push_back('{1, 1, 0, SIZE_WORD, 0, 32'h40, 32'hCAFEF00D, 32'h00000000, 0, 1, 32'h20});
        vecs.push_back('{1, 0, 0, SIZE_WORD, 0, 32'h00, 32'h0,        32'hCAFEF00D, 0, 1, 32'h20});
        vecs.push_back('{1, 0, 0, SIZE_WORD, 0, 32'h80, 32'h0,        32'hCAFEF00D, 0, 1, 32'h20});
        vecs.push_back('{1, 0, 0, SIZE_HALF, 0, 32'h42, 32'h0,        32'h0000CAFE, 0, 1, 32'h20});
        vecs.push_back('{1, 0, 0, SIZE_BYTE, 1, 32'h41, 32'h0,        32'hFFFFFFF0, 0, 1, 32'h20});
        vecs.push_back('{1, 1, 0, SIZE_HALF, 0, 32'h46, 32'h00001234, 32'h00000000, 0, 1, 32'h20});
        vecs.push_back('{1, 0, 0, SIZE_WORD, 0, 32'h04, 32'h0,        32'h12340000, 0, 1, 32'h20});
        vecs.push_back('{1, 1, 0, SIZE_WORD, 0, 32'h10, 32'h11112222, 32'h00000000, 0, 1, 32'h20});

        // Reset for two cycles, then the zero-fill.
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
        #1;
        chk("reset_busy", {31'h0, busy}, 32'h1);
        chk("reset_err", {31'h0, err}, 32'h0);
        chk("reset_err_addr", err_addr, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        count_busy("clear", 1'b0, cnt);
        chk("clear_err_after", {31'h0, err}, 32'h0);
        check_all_zero("clear");

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
        @(negedge clk);
        en = 1'b0; err_clr = 1'b0;

        // Read-during-write: the load earlier in the store cycle still sees old data.
        @(negedge clk);
        drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0);
        #1;
        $display("rdw load-before-store addr=0x10 rdata=0x%08h", rdata);
        chk("rdw_old", rdata, 32'h11112222);
        we = 1'b1; wdata = 32'hAAAA5555;
        #1;
        chk("rdw_store_rdata", rdata, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0);
        #1;
        $display("rdw load-after-store addr=0x10 rdata=0x%08h", rdata);
        chk("rdw_new", rdata, 32'hAAAA5555);

        // Leave err set, then reset mid-clear at clear cycle 5.
        @(negedge clk);
        drive(1'b1, 1'b0, SIZE_HALF, 1'b0, 32'h5, 32'h0);
        @(negedge clk);
        en = 1'b0;
        #1;
        chk("pre_reset_err", {31'h0, err}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midclear_err", {31'h0, err}, 32'h0);
        chk("midclear_err_addr", err_addr, 32'h0);
        chk("midclear_busy", {31'h0, busy}, 32'h1);
        rst = 1'b0;
        count_busy("restart", 1'b1, cnt);
        $display("restart clear busy cycles=%0d", cnt);
        check_all_zero("restart");
        chk("restart_err", {31'h0, err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
